div_iter_unit: RTL and testbench

- Parameterised iterative radix-2 restoring divider for the EX stage.
- Generalised successor to the fixed 32-bit divider: configurable WIDTH, per-operation signed/unsigned mode, working annul, divide-by-zero detection and explicit valid/busy handshake.
- Output format matches the hi/lo register convention, {remainder, quotient}, 2*WIDTH bits.
- The hazard unit consumes stall_div and holds F/D/E stages until the result is valid.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_step.sv | 24 ++
 rtl/div_iter_unit.sv | 114 +++++++++++
 tb/tb_div_iter_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
// Holds the FSM state encoding and the result packing order.
package div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } divState_e;

  // Remainder occupies the high half of result, matching the hi/lo registers.
  localparam bit RESULT_REM_HIGH = 1'b1;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit,
// try subtracting the divisor, keep the difference only if it did not go negative.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] remIn,
  input  logic             dividendBit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remOut,
  output logic             quotBit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // remIn < divisor always holds, so bit WIDTH of trial is a clean sign bit.
  assign shifted = {remIn, dividendBit};
  assign trial   = shifted - {1'b0, divisor};
  assign quotBit = ~trial[WIDTH];
  assign remOut  = quotBit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_iter_unit.sv
// Iterative radix-2 restoring divider for the EX stage, signed or unsigned per op.
// Produces {remainder, quotient} after WIDTH+1 cycles, or after one cycle on divide by zero.
module div_iter_unit
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic               annul,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] result,
  output logic               valid,
  output logic               div_by_zero,
  output logic               stall_div
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  divState_e        state, stateNext;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] remReg, quoReg, divisorAbs;
  logic             signQ, signR;

  logic             accept, lastStep, divisorZero;
  logic [WIDTH-1:0] dividendAbsIn, divisorAbsIn;
  logic [WIDTH-1:0] stepRem, quoFinal, quoFixed, remFixed;
  logic             stepBit;

  function automatic logic [2*WIDTH-1:0] packResult(input logic [WIDTH-1:0] rem,
                                                    input logic [WIDTH-1:0] quo);
    return RESULT_REM_HIGH ? {rem, quo} : {quo, rem};
  endfunction

  assign accept        = (state == DIV_IDLE) & start & ~annul;
  assign lastStep      = (state == DIV_BUSY) && (count == CNT_W'(WIDTH - 1));
  assign divisorZero   = (divisor == '0);
  assign stall_div     = accept | (state == DIV_BUSY);
  assign dividendAbsIn = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign divisorAbsIn  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  // quoReg doubles as the dividend shift register: its MSB feeds the step, quotient bits enter at the LSB.
  div_step #(.WIDTH(WIDTH)) uStep (
    .remIn      (remReg),
    .dividendBit(quoReg[WIDTH-1]),
    .divisor    (divisorAbs),
    .remOut     (stepRem),
    .quotBit    (stepBit)
  );

  assign quoFinal = {quoReg[WIDTH-2:0], stepBit};
  assign quoFixed = signQ ? -quoFinal : quoFinal;
  assign remFixed = signR ? -stepRem  : stepRem;

  always_comb begin
    stateNext = state;
    case (state)
      DIV_IDLE: if (accept) stateNext = divisorZero ? DIV_DONE : DIV_BUSY;
      DIV_BUSY: begin
        if (annul)         stateNext = DIV_IDLE;
        else if (lastStep) stateNext = DIV_DONE;
      end
      DIV_DONE: stateNext = DIV_IDLE;
      default:  stateNext = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DIV_IDLE;
    else     state <= stateNext;
  end

  // An annul in DIV_BUSY simply stops updating; result and valid are left untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= '0;
      remReg      <= '0;
      quoReg      <= '0;
      divisorAbs  <= '0;
      signQ       <= 1'b0;
      signR       <= 1'b0;
      result      <= '0;
      valid       <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (accept) begin
        count       <= '0;
        remReg      <= '0;
        quoReg      <= dividendAbsIn;
        divisorAbs  <= divisorAbsIn;
        signQ       <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        signR       <= is_signed & dividend[WIDTH-1];
        div_by_zero <= divisorZero;
        if (divisorZero) begin
          result <= packResult(dividend, '1);
          valid  <= 1'b1;
        end
      end else if (state == DIV_BUSY && !annul) begin
        remReg <= stepRem;
        quoReg <= quoFinal;
        count  <= count + 1'b1;
        if (lastStep) begin
          result <= packResult(remFixed, quoFixed);
          valid  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed, table-driven bench for div_iter_unit at WIDTH=32, plus
// hand-written sequences for annul, ignored start and asynchronous reset.
module tb_div_iter_unit;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst, start, is_signed, annul;
  logic [W-1:0]   dividend, divisor;
  logic [2*W-1:0] result;
  logic           valid, div_by_zero, stall_div;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic       sgn;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] expRes;
    logic       expDbz;
  } vec_t;

  vec_t vecs[11];

  div_iter_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_signed  (is_signed),
    .annul      (annul),
    .dividend   (dividend),
    .divisor    (divisor),
    .result     (result),
    .valid      (valid),
    .div_by_zero(div_by_zero),
    .stall_div  (stall_div)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Launch one op in cycle 0, scramble the operand inputs afterwards, and wait (bounded) for valid.
  task automatic applyStimulus(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                               output int lat, output logic [2*W-1:0] res,
                               output logic dbz, output int stallCnt);
    @(posedge clk); #1;
    start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
    @(negedge clk);
    stallCnt = stall_div ? 1 : 0;
    @(posedge clk); #1;
    start = 1'b0; is_signed = ~sgn; dividend = 32'hDEADBEEF; divisor = '0;
    lat = -1; res = '0; dbz = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (stall_div) stallCnt++;
      if (valid) begin
        lat = c; res = result; dbz = div_by_zero;
        break;
      end
    end
  endtask

  initial begin
    int lat, stallCnt;
    logic [2*W-1:0] res, held;
    logic dbz, sawValid;

    vecs[0]  = '{"u100_7",    1'b0, 32'd100,      32'd7,        64'h00000002_0000000E, 1'b0};
    vecs[1]  = '{"s-7_2",     1'b1, 32'hFFFFFFF9, 32'h2,        64'hFFFFFFFF_FFFFFFFD, 1'b0};
    vecs[2]  = '{"u-7_2",     1'b0, 32'hFFFFFFF9, 32'h2,        64'h00000001_7FFFFFFC, 1'b0};
    vecs[3]  = '{"s_ovf",     1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0};
    vecs[4]  = '{"u_dbz",     1'b0, 32'h1234,     32'h0,        64'h00001234_FFFFFFFF, 1'b1};
    vecs[5]  = '{"s7_-2",     1'b1, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0};
    vecs[6]  = '{"u_max_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 1'b0};
    vecs[7]  = '{"s-100_-7",  1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 1'b0};
    vecs[8]  = '{"u5_9",      1'b0, 32'd5,        32'd9,        64'h00000005_00000000, 1'b0};
    vecs[9]  = '{"s0_-5",     1'b1, 32'd0,        32'hFFFFFFFB, 64'h00000000_00000000, 1'b0};
    vecs[10] = '{"s_dbz",     1'b1, 32'hFFFFFFF9, 32'h0,        64'hFFFFFFF9_FFFFFFFF, 1'b1};

    rst = 1'b0; start = 1'b0; is_signed = 1'b0; annul = 1'b0; dividend = '0; divisor = '0;
    #2 rst = 1'b1;
    #2;
    checkOutput("reset_result", 64'(result), 64'h0);
    checkOutput("reset_valid",  64'(valid), 64'h0);
    checkOutput("reset_dbz",    64'(div_by_zero), 64'h0);
    checkOutput("reset_stall",  64'(stall_div), 64'h0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, lat, res, dbz, stallCnt);
      checkOutput({vecs[i].name, "_result"},  64'(res), vecs[i].expRes);
      checkOutput({vecs[i].name, "_dbz"},     64'(dbz), 64'(vecs[i].expDbz));
      checkOutput({vecs[i].name, "_latency"}, 64'(lat), vecs[i].expDbz ? 64'd1 : 64'd33);
      checkOutput({vecs[i].name, "_stall"},   64'(stallCnt), vecs[i].expDbz ? 64'd1 : 64'd33);
      @(negedge clk);
      checkOutput({vecs[i].name, "_pulse"},   64'(valid), 64'h0);
      checkOutput({vecs[i].name, "_hold"},    64'(result), vecs[i].expRes);
    end

    // Annul in cycle 10, with an ignored start in cycle 3.
    held = result;
    sawValid = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start = (c == 3); annul = (c == 10);
      dividend = 32'd50; divisor = 32'd5;
      @(negedge clk);
      if (valid) sawValid = 1'b1;
      if (c == 3)  checkOutput("annul_busy_c3",  64'(stall_div), 64'h1);
      if (c == 10) checkOutput("annul_busy_c10", 64'(stall_div), 64'h1);
    end
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    @(negedge clk);
    checkOutput("annul_stall_idle", 64'(stall_div), 64'h0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (valid) sawValid = 1'b1;
    end
    checkOutput("annul_no_valid", 64'(sawValid), 64'h0);
    checkOutput("annul_result",   64'(result), held);

    // start and annul together in IDLE: nothing accepted.
    @(posedge clk); #1;
    start = 1'b1; annul = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(negedge clk);
    checkOutput("start_annul_stall", 64'(stall_div), 64'h0);
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    @(negedge clk);
    checkOutput("start_annul_idle", 64'(stall_div), 64'h0);

    // Asynchronous reset between edges in the middle of a divide.
    @(posedge clk); #1;
    start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_result", 64'(result), 64'h0);
    checkOutput("arst_valid",  64'(valid), 64'h0);
    checkOutput("arst_dbz",    64'(div_by_zero), 64'h0);
    checkOutput("arst_stall",  64'(stall_div), 64'h0);
    #1 rst = 1'b0;
    applyStimulus(1'b0, 32'd100, 32'd7, lat, res, dbz, stallCnt);
    checkOutput("post_rst_result",  64'(res), 64'h00000002_0000000E);
    checkOutput("post_rst_latency", 64'(lat), 64'd33);
    checkOutput("post_rst_dbz",     64'(dbz), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
